// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: one shared edge- or center-aligned period counter
// and NCH compare channels. Period/compare writes are double-buffered and applied at period boundaries.
module pwm_multi_ch #(
  parameter int CW  = 16,
  parameter int NCH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              center_mode,
  input  logic              upd,
  input  logic [CW-1:0]     max_count,
  input  logic [NCH*CW-1:0] cmp_val,
  output logic [NCH-1:0]    pwm_out,
  output logic              period_strb,
  output logic              upd_pend
);

  logic [CW-1:0]     cnt, cnt_nxt;
  logic              dir_dn, dir_dn_nxt;
  logic [CW-1:0]     max_act, max_shd;
  logic [NCH*CW-1:0] cmp_act, cmp_shd;
  logic              mode_act, mode_shd;
  logic              term;
  logic              apply_shd;

  // A triangle with max_act<=1 has no down slope, so it wraps straight from the top.
  always_comb begin
    term       = 1'b0;
    cnt_nxt    = '0;
    dir_dn_nxt = 1'b0;
    if (mode_act) begin
      if (max_act <= CW'(1)) term = (cnt == max_act);
      else                   term = dir_dn && (cnt == CW'(1));
    end else begin
      term = (cnt == max_act);
    end
    if (en && !term) begin
      if (!mode_act || (!dir_dn && cnt != max_act)) begin
        cnt_nxt    = cnt + 1'b1;
        dir_dn_nxt = dir_dn;
      end else begin
        cnt_nxt    = cnt - 1'b1;
        dir_dn_nxt = 1'b1;
      end
    end
    apply_shd = upd_pend && (!en || term);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      dir_dn      <= 1'b0;
      max_act     <= '0;
      cmp_act     <= '0;
      mode_act    <= 1'b0;
      max_shd     <= '0;
      cmp_shd     <= '0;
      mode_shd    <= 1'b0;
      upd_pend    <= 1'b0;
      pwm_out     <= '0;
      period_strb <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      dir_dn <= dir_dn_nxt;
      if (apply_shd) begin
        max_act  <= max_shd;
        cmp_act  <= cmp_shd;
        mode_act <= mode_shd;
        upd_pend <= 1'b0;
      end
      // A capture on the apply edge refills the shadow and keeps the update pending.
      if (upd) begin
        max_shd  <= max_count;
        cmp_shd  <= cmp_val;
        mode_shd <= center_mode;
        upd_pend <= 1'b1;
      end
      for (int i = 0; i < NCH; i++) begin
        pwm_out[i] <= en && (cnt < cmp_act[i*CW +: CW]);
      end
      period_strb <= en && (cnt_nxt == '0);
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Randomized and directed bench for pwm_multi_ch, checked against a phase-based
// reference model that derives the counter value from position within the period.
module tb_pwm_multi_ch;
  localparam int CW  = 16;
  localparam int NCH = 4;

  logic              clk = 1'b0;
  logic              rst, en, center_mode, upd;
  logic [CW-1:0]     max_count;
  logic [NCH*CW-1:0] cmp_val;
  logic [NCH-1:0]    pwm_out;
  logic              period_strb, upd_pend;

  pwm_multi_ch #(.CW(CW), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .en(en), .center_mode(center_mode), .upd(upd),
    .max_count(max_count), .cmp_val(cmp_val),
    .pwm_out(pwm_out), .period_strb(period_strb), .upd_pend(upd_pend)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: active/shadow settings and phase within the period.
  int   m_max, m_cmp[NCH], s_max, s_cmp[NCH];
  logic m_mode, s_mode, m_pend;
  int   m_phase;
  logic [NCH-1:0] exp_pwm;
  logic exp_strb;

  function automatic int period_len(input int mx, input logic md);
    if (mx == 0) return 1;
    return md ? 2 * mx : mx + 1;
  endfunction

  function automatic int cnt_of(input int ph, input int mx, input logic md);
    if (!md || ph <= mx) return ph;
    return 2 * mx - ph;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step();
    int c, nxt;
    logic bnd;
    logic [NCH-1:0] np;
    if (rst) begin
      m_max = 0; s_max = 0; m_mode = 0; s_mode = 0; m_pend = 0; m_phase = 0;
      for (int i = 0; i < NCH; i++) begin m_cmp[i] = 0; s_cmp[i] = 0; end
      exp_pwm = '0; exp_strb = 1'b0;
      return;
    end
    c = cnt_of(m_phase, m_max, m_mode);
    for (int i = 0; i < NCH; i++) np[i] = en && (c < m_cmp[i]);
    bnd = (m_phase == period_len(m_max, m_mode) - 1);
    nxt = (en && !bnd) ? m_phase + 1 : 0;
    if (m_pend && (!en || bnd)) begin
      m_max = s_max; m_mode = s_mode; m_pend = 1'b0;
      for (int i = 0; i < NCH; i++) m_cmp[i] = s_cmp[i];
    end
    if (upd) begin
      s_max = int'(max_count); s_mode = center_mode; m_pend = 1'b1;
      for (int i = 0; i < NCH; i++) s_cmp[i] = int'(cmp_val[i*CW +: CW]);
    end
    m_phase  = nxt;
    exp_pwm  = np;
    exp_strb = en && (nxt == 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_val("pwm_out", 32'(pwm_out), 32'(exp_pwm));
    check_val("period_strb", 32'(period_strb), 32'(exp_strb));
    check_val("upd_pend", 32'(upd_pend), 32'(m_pend));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic load(input int mx, input logic md, input int c0, input int c1, input int c2, input int c3);
    max_count   = CW'(mx);
    center_mode = md;
    cmp_val     = {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
    upd = 1'b1;
    cycle();
    upd = 1'b0;
  endtask

  task automatic run_to_boundary();
    for (int k = 0; k < 64 && m_phase != period_len(m_max, m_mode) - 1; k++) cycle();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; center_mode = 1'b0; upd = 1'b0;
    max_count = '0; cmp_val = '0;
    run(2);
    rst = 1'b0;
    // Edge mode, max=9, cmp={0,3,5,12}
    en = 1'b1;
    load(9, 1'b0, 0, 3, 5, 12);
    run(32);
    // Center mode, max=4, cmp0=2
    load(4, 1'b1, 2, 0, 5, 1);
    run(26);
    // Back to edge max=9, then mid-period update to max=4, cmp1=2
    load(9, 1'b0, 0, 3, 5, 12);
    run_to_boundary();
    run(6);
    load(4, 1'b0, 0, 2, 4, 7);
    run(20);
    // Update coinciding with a boundary while another is pending
    load(6, 1'b0, 1, 2, 3, 4);
    run_to_boundary();
    load(3, 1'b1, 1, 2, 3, 0);
    run(20);
    // Drop en mid-period with a pending update, raise 3 cycles later
    load(9, 1'b0, 0, 3, 5, 12);
    run_to_boundary();
    run(7);
    load(5, 1'b0, 2, 2, 2, 2);
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(14);
    // Reset mid-period with an update pending
    load(9, 1'b0, 1, 3, 5, 9);
    run_to_boundary();
    run(7);
    load(6, 1'b1, 3, 3, 3, 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(4);
    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      rst         = ($urandom_range(0, 299) == 0);
      en          = ($urandom_range(0, 15) != 0);
      upd         = ($urandom_range(0, 11) == 0);
      center_mode = $urandom_range(0, 1);
      max_count   = CW'($urandom_range(0, 12));
      for (int i = 0; i < NCH; i++) cmp_val[i*CW +: CW] = CW'($urandom_range(0, 14));
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
